// File: rtl/jh_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jh_pkg : shared state encoding and constants for the PWM actuator  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jh_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam int unsigned     c_LVL_W      = 6;
   localparam int unsigned     c_PERIOD_LEN = 64;
   localparam logic [5:0]      c_CEIL_FIXED = 6'd31;
   localparam logic [5:0]      c_CNT_LAST   = 6'(c_PERIOD_LEN - 1);

   // One slew-limited step of the applied level toward the target.
   function automatic logic [c_LVL_W-1:0] slew_step(
      input logic [c_LVL_W-1:0] cur,
      input logic [c_LVL_W-1:0] tgt
   );
      if (cur < tgt) begin
         return cur + 6'd1;
      end else if (cur > tgt) begin
         return cur - 6'd1;
      end else begin
         return cur;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/jh_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jh_tick_gen : DIV prescaler with enable and synchronous clear      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jh_tick_gen #(
   parameter int unsigned DIV = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned      c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_CW-1:0]  c_LAST = c_CW'(DIV - 1);

   logic [c_CW-1:0] cnt_q;
   logic [c_CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/jh_pwm_actuator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jh_pwm_actuator : slew-limited, ceiling-clamped heater PWM driver  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jh_pwm_actuator
   import jh_pkg::*;
#(
   parameter int unsigned DIV         = 16,
   parameter int unsigned UPD_PERIODS = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       i_fault,
   input  logic [5:0] i_level,
   input  logic [5:0] max_power,
   input  logic       power_unlock,
   output logic       pwm_out,
   output logic       o_update,
   output logic [5:0] o_level,
   output logic       o_clamped,
   output logic       o_busy
);

   localparam logic [3:0] c_UPD_LAST = 4'(UPD_PERIODS - 1);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] cnt_q;
   logic [5:0] cnt_d;
   logic [5:0] level_q;
   logic [5:0] level_d;
   logic [3:0] bcnt_q;
   logic [3:0] bcnt_d;
   logic       pwm_q;
   logic       pwm_d;
   logic       upd_q;
   logic       upd_d;

   logic       w_tick;
   logic       w_tick_en;
   logic       w_active_d;
   logic       w_boundary;
   logic [5:0] w_ceiling;
   logic [5:0] w_target;

   assign w_ceiling  = power_unlock ? max_power : c_CEIL_FIXED;
   assign o_clamped  = (i_level > w_ceiling);
   assign w_target   = (state_q == ST_DRAIN) ? 6'd0
                     : (o_clamped ? w_ceiling : i_level);
   assign w_tick_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign w_active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
   assign w_boundary = w_tick && (cnt_q == c_CNT_LAST);

   jh_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .en_i   (w_tick_en),
      .clr_i  (!w_active_d),
      .tick_o (w_tick)
   );

   // Fault is tested first in every state so it wins over enable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (!enable) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (enable) begin
               state_d = ST_RUN;
            end else if (w_boundary && (level_q == 6'd0)) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (!i_fault && !enable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      bcnt_d  = bcnt_q;
      upd_d   = 1'b0;

      if (!w_active_d) begin
         cnt_d   = '0;
         level_d = '0;
      end else begin
         if (w_tick) begin
            cnt_d = cnt_q + 6'd1;
         end
         if (w_boundary) begin
            level_d = slew_step(level_q, w_target);
         end
      end

      // Strobe only while staying in RUN so none leaks into DRAIN or FAULT.
      if (state_d != ST_RUN) begin
         bcnt_d = '0;
      end else if (w_boundary && (state_q == ST_RUN)) begin
         if (bcnt_q == c_UPD_LAST) begin
            bcnt_d = '0;
            upd_d  = 1'b1;
         end else begin
            bcnt_d = bcnt_q + 4'd1;
         end
      end

      pwm_d = w_active_d && (cnt_d < level_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= '0;
         bcnt_q  <= '0;
         pwm_q   <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         bcnt_q  <= bcnt_d;
         pwm_q   <= pwm_d;
         upd_q   <= upd_d;
      end
   end

   assign pwm_out  = pwm_q;
   assign o_update = upd_q;
   assign o_level  = level_q;
   assign o_busy   = w_tick_en;

endmodule
`default_nettype wire

// File: tb/tb_jh_pwm_actuator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jh_pwm_actuator : scoreboard bench for the heater PWM actuator  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jh_pwm_actuator;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       en2;
   logic       i_fault;
   logic       power_unlock;
   logic [5:0] i_level;
   logic [5:0] max_power;

   logic       pwm_out, o_update, o_clamped, o_busy;
   logic [5:0] o_level;
   logic       pwm2, upd2, clamped2, busy2;
   logic [5:0] level2;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int exp_lvl[$];
   int exp_upd[$];

   jh_pwm_actuator #(.DIV(1), .UPD_PERIODS(4)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .i_fault      (i_fault),
      .i_level      (i_level),
      .max_power    (max_power),
      .power_unlock (power_unlock),
      .pwm_out      (pwm_out),
      .o_update     (o_update),
      .o_level      (o_level),
      .o_clamped    (o_clamped),
      .o_busy       (o_busy)
   );

   jh_pwm_actuator #(.DIV(2), .UPD_PERIODS(4)) u_dut2 (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (en2),
      .i_fault      (i_fault),
      .i_level      (i_level),
      .max_power    (max_power),
      .power_unlock (power_unlock),
      .pwm_out      (pwm2),
      .o_update     (upd2),
      .o_level      (level2),
      .o_clamped    (clamped2),
      .o_busy       (busy2)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget && exp_lvl.size() != 0; i++) begin
         @(negedge clock);
         #1;
      end
      chk("sb_drain", exp_lvl.size(), 0);
   endtask

   task automatic wait_pwm_high(input int budget);
      int found;
      found = 0;
      for (int i = 0; i < budget && found == 0; i++) begin
         @(negedge clock);
         #1;
         if (pwm_out) found = 1;
      end
      chk("pwm_seen_high", found, 1);
   endtask

   task automatic count_pwm(input string name, input int exp);
      int n;
      n = 0;
      repeat (64) begin
         @(negedge clock);
         #1;
         if (pwm_out) n++;
      end
      chk(name, n, exp);
   endtask

   // Monitor: every change of the applied level and every update strobe is
   // matched against the next expected entry.
   initial begin : mon
      logic [5:0] prev_lvl;
      logic       prev_upd;
      int         e;
      prev_lvl = 6'd0;
      prev_upd = 1'b0;
      forever begin
         @(negedge clock);
         if (o_level != prev_lvl) begin
            if (exp_lvl.size() == 0) begin
               chk("lvl_unexpected", int'(o_level), int'(prev_lvl));
            end else begin
               e = exp_lvl.pop_front();
               chk("lvl_seq", int'(o_level), e);
            end
            prev_lvl = o_level;
         end
         if (prev_upd) begin
            chk("upd_width", int'(upd2), 0);
         end else if (upd2) begin
            if (exp_upd.size() == 0) begin
               chk("upd_unexpected", cyc, -1);
            end else begin
               e = exp_upd.pop_front();
               chk("upd_cycle", cyc, e);
            end
         end
         if (o_update) chk("upd1_busy", int'(o_busy), 1);
         prev_upd = upd2;
      end
   end

   initial begin : stim
      int c0;
      reset_n      = 1'b1;
      enable       = 1'b0;
      en2          = 1'b0;
      i_fault      = 1'b0;
      power_unlock = 1'b0;
      i_level      = 6'd0;
      max_power    = 6'd0;
      #2 reset_n = 1'b0;
      #10;
      chk("rst_pwm",   int'(pwm_out),  0);
      chk("rst_upd",   int'(o_update), 0);
      chk("rst_level", int'(o_level),  0);
      chk("rst_busy",  int'(o_busy),   0);
      chk("rst_pwm2",  int'(pwm2),     0);
      chk("rst_upd2",  int'(upd2),     0);
      @(negedge clock);
      #1 reset_n = 1'b1;
      tick_n(2);

      // Update strobe spacing on the DIV=2 instance: 4 periods of 128 clocks.
      c0  = cyc;
      en2 = 1'b1;
      exp_upd.push_back(c0 + 513);
      exp_upd.push_back(c0 + 1025);
      exp_upd.push_back(c0 + 1537);
      tick_n(1540);
      en2 = 1'b0;
      tick_n(140);
      chk("upd2_idle", int'(busy2), 0);
      chk("upd_q_empty", exp_upd.size(), 0);
      tick_n(600);

      // Soft-start ramp to 10, then 10/64 duty.
      i_level = 6'd10;
      enable  = 1'b1;
      for (int v = 1; v <= 10; v++) exp_lvl.push_back(v);
      wait_sb(12 * 64);
      chk("ramp_level", int'(o_level), 10);
      chk("ramp_clamped", int'(o_clamped), 0);
      count_pwm("duty_10", 10);

      // Clamp at the fixed ceiling, then unlocked ceiling, then ceiling drop.
      i_level = 6'd50;
      #1 chk("clamp_fixed", int'(o_clamped), 1);
      for (int v = 11; v <= 31; v++) exp_lvl.push_back(v);
      wait_sb(23 * 64);
      power_unlock = 1'b1;
      max_power    = 6'd40;
      #1 chk("clamp_unlock", int'(o_clamped), 1);
      for (int v = 32; v <= 40; v++) exp_lvl.push_back(v);
      wait_sb(11 * 64);
      chk("unlock_level", int'(o_level), 40);
      max_power = 6'd35;
      for (int v = 39; v >= 35; v--) exp_lvl.push_back(v);
      wait_sb(7 * 64);

      // Slew down to 5, then drain to 0 and return to IDLE.
      i_level = 6'd5;
      #1 chk("unclamped", int'(o_clamped), 0);
      for (int v = 34; v >= 5; v--) exp_lvl.push_back(v);
      wait_sb(32 * 64);
      enable = 1'b0;
      for (int v = 4; v >= 0; v--) exp_lvl.push_back(v);
      wait_sb(7 * 64);
      chk("drain_busy", int'(o_busy), 1);
      tick_n(63);
      chk("drain_busy_late", int'(o_busy), 1);
      tick_n(1);
      chk("idle_busy", int'(o_busy), 0);
      chk("idle_pwm", int'(pwm_out), 0);

      // Fault and enable drop together during a high phase.
      enable = 1'b1;
      for (int v = 1; v <= 5; v++) exp_lvl.push_back(v);
      wait_sb(7 * 64);
      wait_pwm_high(200);
      exp_lvl.push_back(0);
      i_fault = 1'b1;
      enable  = 1'b0;
      tick_n(1);
      chk("fault_pwm", int'(pwm_out), 0);
      chk("fault_busy", int'(o_busy), 0);
      i_fault = 1'b0;
      enable  = 1'b1;
      tick_n(10);
      chk("fault_hold", int'(o_busy), 0);
      enable  = 1'b0;
      i_level = 6'd3;
      tick_n(2);
      enable = 1'b1;
      for (int v = 1; v <= 3; v++) exp_lvl.push_back(v);
      tick_n(2);
      chk("fault_exit_run", int'(o_busy), 1);
      wait_sb(5 * 64);

      // Asynchronous reset in the middle of a high phase.
      wait_pwm_high(200);
      exp_lvl.push_back(0);
      reset_n = 1'b0;
      #1;
      chk("arst_pwm",   int'(pwm_out),  0);
      chk("arst_level", int'(o_level),  0);
      chk("arst_upd",   int'(o_update), 0);
      chk("arst_busy",  int'(o_busy),   0);
      i_level = 6'd0;
      tick_n(3);
      reset_n = 1'b1;
      count_pwm("post_rst_pwm", 0);
      enable = 1'b0;
      tick_n(80);
      chk("end_idle", int'(o_busy), 0);
      chk("lvl_q_empty", exp_lvl.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jh_pwm_actuator.md
JH_PWM_ACTUATOR -- requirements
Module: jh_pwm_actuator

Interface
REQ-001 SHALL provide parameter DIV, default 16, the number of clock cycles per PWM tick (range 1..256).
REQ-002 SHALL provide parameter UPD_PERIODS, default 4, the number of completed PWM periods between update strobes (range 1..15).
REQ-003 SHALL have port clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  run request, level-sensitive.
REQ-006 SHALL have port i_fault  in  1  synchronous hard-off request, level-sensitive.
REQ-007 SHALL have port i_level  in  6  requested power level; this is the feedback controller output.
REQ-008 SHALL have port max_power  in  6  unlocked power ceiling.
REQ-009 SHALL have port power_unlock  in  1  1 selects max_power as the ceiling, 0 selects the fixed ceiling 31.
REQ-010 SHALL have port pwm_out  out  1  heater drive, registered.
REQ-011 SHALL have port o_update  out  1  one-clock strobe that drives the feedback controller en_RF input.
REQ-012 SHALL have port o_level  out  6  duty level currently applied.
REQ-013 SHALL have port o_clamped  out  1  high while the requested level exceeds the ceiling.
REQ-014 SHALL have port o_busy  out  1  high in states RUN and DRAIN.

Function
REQ-015 SHALL run the prescaler (0..DIV-1) and issue tick for one clock when it wraps; the prescaler runs only outside IDLE and FAULT.
REQ-016 SHALL advance a 6-bit period counter (0..63) once per tick; boundary = tick with counter at 63, after which the counter wraps to 0.
REQ-017 SHALL drive pwm_out = 1 iff state is RUN or DRAIN and counter < o_level; level 0 never drives high, level 63 gives 63/64 duty (never fully on).
REQ-018 SHALL compute target = min(i_level, ceiling), where ceiling = power_unlock ? max_power : 31; o_clamped = (i_level > ceiling), combinational.
REQ-019 SHALL update o_level only at a boundary, moving at most 1 step per period toward target (slew limit); with no change needed o_level holds.
REQ-020 SHALL step o_level down at the next boundary when the ceiling drops below o_level, and keep stepping until o_level <= ceiling.
REQ-021 SHALL use states IDLE, RUN, DRAIN, FAULT.
REQ-022 SHALL move IDLE->RUN on enable=1 and i_fault=0; the prescaler and counter start from 0 and o_level starts at 0 (soft start).
REQ-023 SHALL move RUN->DRAIN on enable=0; in DRAIN the target is forced to 0 and the block moves DRAIN->IDLE at the first boundary where o_level is 0.
REQ-024 SHALL move DRAIN->RUN when enable returns to 1 before drain completes, with no counter reset.
REQ-025 SHALL move any state->FAULT on i_fault=1; the next clock gives pwm_out=0 and o_level=0, and counters clear. FAULT->IDLE only when i_fault=0 and enable=0.
REQ-026 SHALL give i_fault priority over enable when both change in the same cycle.
REQ-027 SHALL count boundaries in RUN; o_update pulses one clock after each UPD_PERIODS-th boundary, then the boundary count clears. No strobe in IDLE, DRAIN or FAULT; the boundary count clears on leaving RUN.
REQ-028 SHALL sample i_level at a boundary, using the value present in that cycle.

Reset
REQ-029 SHALL asynchronously, on reset_n=0, force state IDLE, all counters 0, pwm_out=0, o_update=0, o_level=0.
REQ-030 SHALL resume operation on the first rising clock edge after reset_n deasserts; reset asserted mid-period abandons the period with no partial pulse afterwards.

Structure
REQ-031 SHALL take the state encoding, the fixed ceiling 31, and the period length 64 from shared package jh_pkg.
REQ-032 SHALL contain one sub-module, jh_tick_gen (the DIV prescaler with enable and synchronous clear).

Verification
REQ-033 SHALL cover: DIV=1, enable, i_level=10 -> o_level reaches 10 after 10 boundaries; pwm_out high 10 of every 64 clocks thereafter.
REQ-034 SHALL cover: power_unlock=0, i_level=50 -> o_clamped=1, o_level settles at 31; then power_unlock=1, max_power=40 -> o_level settles at 40.
REQ-035 SHALL cover: UPD_PERIODS=4, DIV=2 -> o_update single-clock pulses exactly 512 clocks apart in RUN; none in IDLE.
REQ-036 SHALL cover: o_level=5, enable drop -> DRAIN, o_level 4,3,2,1,0 on successive boundaries, then IDLE, pwm_out=0.
REQ-037 SHALL cover: i_fault and enable drop in the same cycle during a pwm high phase -> pwm_out=0 next clock, state FAULT; leaves FAULT only with both low.
REQ-038 SHALL cover: reset_n pulsed low mid-high-phase with no clock edge -> pwm_out=0 immediately; all outputs at reset values.
